// File: rtl/tmr_voter_pkg.sv
// Shared definitions for the TMR voter monitor: replica indices, blame vector
// type and a width-generic saturating incrementer.
package tmr_voter_pkg;

    localparam int unsigned R0 = 0;
    localparam int unsigned R1 = 1;
    localparam int unsigned R2 = 2;

    // Widest counter the saturating incrementer supports
    localparam int unsigned SAT_W = 64;

    typedef logic [2:0] blame_t;

    // Increment v, sticking at 2^w-1; w must not exceed SAT_W
    function automatic logic [SAT_W-1:0] sat_inc(input logic [SAT_W-1:0] v,
                                                 input int unsigned        w);
        logic [SAT_W-1:0] max_v;
        max_v = (w >= SAT_W) ? '1 : ((SAT_W'(1) << w) - SAT_W'(1));
        return (v >= max_v) ? max_v : v + SAT_W'(1);
    endfunction

endpackage

// File: rtl/tmr_vote_lane.sv
// Combinational majority vote of one W-bit channel across three replicas,
// reporting recoverable/unrecoverable mismatch and the outvoted replica.
module tmr_vote_lane
    import tmr_voter_pkg::*;
#(
    parameter int unsigned W = 32
) (
    input  logic [W-1:0] in0_i,
    input  logic [W-1:0] in1_i,
    input  logic [W-1:0] in2_i,
    output logic [W-1:0] out_o,
    output logic         err1_o,
    output logic         err2_o,
    output blame_t       blame_o
);

    logic eq01, eq02, eq12;

    assign eq01 = (in0_i == in1_i);
    assign eq02 = (in0_i == in2_i);
    assign eq12 = (in1_i == in2_i);

    always_comb begin
        out_o   = in0_i;
        err1_o  = 1'b0;
        err2_o  = 1'b0;
        blame_o = '0;
        if (eq01 && eq02) begin
            err1_o = 1'b0;
        end else if (eq01) begin
            err1_o      = 1'b1;
            blame_o[R2] = 1'b1;
        end else if (eq02) begin
            err1_o      = 1'b1;
            blame_o[R1] = 1'b1;
        end else if (eq12) begin
            out_o       = in1_i;
            err1_o      = 1'b1;
            blame_o[R0] = 1'b1;
        end else begin
            // No majority: pass replica 0 through and flag it as unrecoverable
            err1_o = 1'b1;
            err2_o = 1'b1;
        end
    end

endmodule

// File: rtl/tmr_voter_monitor.sv
// Registered C-channel TMR voter with sticky error status, per-replica fault
// counters and threshold irq; counters/irq exist only with TMR_VOTER_CNT_EN.
module tmr_voter_monitor
    import tmr_voter_pkg::*;
#(
    parameter int unsigned W     = 32,
    parameter int unsigned C     = 4,
    parameter int unsigned CNT_W = 16
) (
    input  logic                clk_i,
    input  logic                rstn_i,
    input  logic                valid_i,
    input  logic [C-1:0][W-1:0] in0_i,
    input  logic [C-1:0][W-1:0] in1_i,
    input  logic [C-1:0][W-1:0] in2_i,
    input  logic                clr_i,
    input  logic [CNT_W-1:0]    thr_i,
    output logic                valid_o,
    output logic [C-1:0][W-1:0] out_o,
    output logic [C-1:0]        err1_ch_o,
    output logic [C-1:0]        err2_ch_o,
    output logic                error1_o,
    output logic                error2_o,
    output logic [2:0]          blame_o,
    output logic                sticky1_o,
    output logic                sticky2_o,
    output logic [CNT_W-1:0]    cnt0_o,
    output logic [CNT_W-1:0]    cnt1_o,
    output logic [CNT_W-1:0]    cnt2_o,
    output logic [CNT_W-1:0]    cntu_o,
    output logic                irq_o
);

    logic [C-1:0][W-1:0] lane_out;
    logic [C-1:0]        lane_err1;
    logic [C-1:0]        lane_err2;
    blame_t [C-1:0]      lane_blame;
    blame_t              blame_any;

    genvar g;
    for (g = 0; g < C; g++) begin : g_lane
        tmr_vote_lane #(.W(W)) u_lane (
            .in0_i  (in0_i[g]),
            .in1_i  (in1_i[g]),
            .in2_i  (in2_i[g]),
            .out_o  (lane_out[g]),
            .err1_o (lane_err1[g]),
            .err2_o (lane_err2[g]),
            .blame_o(lane_blame[g])
        );
    end

    always_comb begin
        blame_any = '0;
        for (int unsigned i = 0; i < C; i++) begin
            blame_any = blame_any | lane_blame[i];
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            valid_o   <= 1'b0;
            out_o     <= '0;
            err1_ch_o <= '0;
            err2_ch_o <= '0;
            blame_o   <= '0;
        end else begin
            valid_o <= valid_i;
            if (valid_i) begin
                out_o     <= lane_out;
                err1_ch_o <= lane_err1;
                err2_ch_o <= lane_err2;
                blame_o   <= blame_any;
            end else begin
                err1_ch_o <= '0;
                err2_ch_o <= '0;
                blame_o   <= '0;
            end
        end
    end

    assign error1_o = |err1_ch_o;
    assign error2_o = |err2_ch_o;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            sticky1_o <= 1'b0;
            sticky2_o <= 1'b0;
        end else if (clr_i) begin
            sticky1_o <= 1'b0;
            sticky2_o <= 1'b0;
        end else if (valid_i) begin
            if (|lane_err1) sticky1_o <= 1'b1;
            if (|lane_err2) sticky2_o <= 1'b1;
        end
    end

`ifdef TMR_VOTER_CNT_EN
    localparam int unsigned CNTU = 3;

    logic [3:0]            hit;
    logic [3:0][CNT_W-1:0] cnt_q;
    logic [3:0][CNT_W-1:0] cnt_nxt;
    logic                  thr_hit;

    assign hit = {valid_i & (|lane_err2), {3{valid_i}} & blame_any};

    // Threshold is checked against the post-increment values so irq lines up
    // with the sample that crosses it
    always_comb begin
        thr_hit = 1'b0;
        for (int unsigned i = 0; i < 4; i++) begin
            cnt_nxt[i] = hit[i] ? CNT_W'(sat_inc(SAT_W'(cnt_q[i]), CNT_W)) : cnt_q[i];
            if ((thr_i != '0) && (cnt_nxt[i] >= thr_i)) thr_hit = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            cnt_q <= '0;
            irq_o <= 1'b0;
        end else if (clr_i) begin
            cnt_q <= '0;
            irq_o <= 1'b0;
        end else begin
            cnt_q <= cnt_nxt;
            if (thr_hit) irq_o <= 1'b1;
        end
    end

    assign cnt0_o = cnt_q[R0];
    assign cnt1_o = cnt_q[R1];
    assign cnt2_o = cnt_q[R2];
    assign cntu_o = cnt_q[CNTU];
`else
    logic unused_thr;
    assign unused_thr = ^thr_i;

    assign cnt0_o = '0;
    assign cnt1_o = '0;
    assign cnt2_o = '0;
    assign cntu_o = '0;
    assign irq_o  = 1'b0;
`endif

endmodule

// File: tb/tb_tmr_voter_monitor.sv
// Randomised self-checking bench for tmr_voter_monitor against a rule-level
// reference model; counter expectations follow TMR_VOTER_CNT_EN.
module tb_tmr_voter_monitor;

    localparam int unsigned W     = 32;
    localparam int unsigned C     = 4;
    localparam int unsigned CNT_W = 4;
    localparam int          CMAX  = (1 << CNT_W) - 1;
    localparam int unsigned VEC_W = 1 + C*W + C + C + 1 + 1 + 3 + 1 + 1 + 4*CNT_W + 1;

    logic                clk_i = 1'b0;
    logic                rstn_i;
    logic                valid_i;
    logic [C-1:0][W-1:0] in0_i, in1_i, in2_i;
    logic                clr_i;
    logic [CNT_W-1:0]    thr_i;
    logic                valid_o;
    logic [C-1:0][W-1:0] out_o;
    logic [C-1:0]        err1_ch_o, err2_ch_o;
    logic                error1_o, error2_o;
    logic [2:0]          blame_o;
    logic                sticky1_o, sticky2_o;
    logic [CNT_W-1:0]    cnt0_o, cnt1_o, cnt2_o, cntu_o;
    logic                irq_o;

    tmr_voter_monitor #(.W(W), .C(C), .CNT_W(CNT_W)) dut (
        .clk_i(clk_i), .rstn_i(rstn_i), .valid_i(valid_i),
        .in0_i(in0_i), .in1_i(in1_i), .in2_i(in2_i),
        .clr_i(clr_i), .thr_i(thr_i),
        .valid_o(valid_o), .out_o(out_o),
        .err1_ch_o(err1_ch_o), .err2_ch_o(err2_ch_o),
        .error1_o(error1_o), .error2_o(error2_o), .blame_o(blame_o),
        .sticky1_o(sticky1_o), .sticky2_o(sticky2_o),
        .cnt0_o(cnt0_o), .cnt1_o(cnt1_o), .cnt2_o(cnt2_o), .cntu_o(cntu_o),
        .irq_o(irq_o)
    );

    always #5 clk_i = ~clk_i;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    logic                e_valid;
    logic [C-1:0][W-1:0] e_out;
    logic [C-1:0]        e_err1, e_err2;
    logic [2:0]          e_blame;
    logic                e_st1, e_st2, e_irq;
    int                  m_cnt [4];

    logic [VEC_W-1:0] act_vec;
    assign act_vec = {valid_o, out_o, err1_ch_o, err2_ch_o, error1_o, error2_o, blame_o,
                      sticky1_o, sticky2_o, cnt0_o, cnt1_o, cnt2_o, cntu_o, irq_o};

    function automatic logic [VEC_W-1:0] exp_vec();
        logic [3:0][CNT_W-1:0] c;
        logic                  irq;
`ifdef TMR_VOTER_CNT_EN
        for (int k = 0; k < 4; k++) c[k] = CNT_W'(m_cnt[k]);
        irq = e_irq;
`else
        c   = '0;
        irq = 1'b0;
`endif
        return {e_valid, e_out, e_err1, e_err2, |e_err1, |e_err2, e_blame,
                e_st1, e_st2, c[0], c[1], c[2], c[3], irq};
    endfunction

    task automatic model_reset();
        e_valid = 1'b0; e_out = '0; e_err1 = '0; e_err2 = '0; e_blame = '0;
        e_st1 = 1'b0; e_st2 = 1'b0; e_irq = 1'b0;
        for (int k = 0; k < 4; k++) m_cnt[k] = 0;
    endtask

    // Drives one cycle of stimulus and advances the model to what the DUT
    // should show #1 after the next rising edge.
    task automatic apply(input logic v, input logic [C-1:0][W-1:0] a, b, c,
                         input logic clr, input logic [CNT_W-1:0] thr);
        logic [W-1:0] x, y, z;
        @(negedge clk_i);
        valid_i = v; in0_i = a; in1_i = b; in2_i = c; clr_i = clr; thr_i = thr;
        e_valid = v; e_err1 = '0; e_err2 = '0; e_blame = '0;
        if (v) begin
            for (int ch = 0; ch < C; ch++) begin
                x = a[ch]; y = b[ch]; z = c[ch];
                if (x == y && y == z) begin
                    e_out[ch] = x;
                end else if (x != y && y != z && x != z) begin
                    e_out[ch] = x; e_err1[ch] = 1'b1; e_err2[ch] = 1'b1;
                end else begin
                    e_err1[ch] = 1'b1;
                    e_out[ch]  = (y == z) ? y : x;
                    if (y == z) e_blame[0] = 1'b1;
                    if (x == z) e_blame[1] = 1'b1;
                    if (x == y) e_blame[2] = 1'b1;
                end
            end
        end
        if (clr) begin
            for (int k = 0; k < 4; k++) m_cnt[k] = 0;
            e_st1 = 1'b0; e_st2 = 1'b0; e_irq = 1'b0;
        end else begin
            if (v) begin
                if (|e_err1) e_st1 = 1'b1;
                if (|e_err2) e_st2 = 1'b1;
                for (int k = 0; k < 3; k++)
                    if (e_blame[k] && m_cnt[k] < CMAX) m_cnt[k]++;
                if (|e_err2 && m_cnt[3] < CMAX) m_cnt[3]++;
            end
            if (thr != 0)
                for (int k = 0; k < 4; k++)
                    if (m_cnt[k] >= int'(thr)) e_irq = 1'b1;
        end
        @(posedge clk_i);
        #1;
    endtask

    function automatic logic [C-1:0][W-1:0] fill(input logic [W-1:0] v);
        logic [C-1:0][W-1:0] r;
        for (int ch = 0; ch < C; ch++) r[ch] = v;
        return r;
    endfunction

    task automatic test_reset();
        rstn_i = 1'b0; valid_i = 1'b0; clr_i = 1'b0; thr_i = '0;
        in0_i = '0; in1_i = '0; in2_i = '0;
        model_reset();
        #1;
        n_cmp++;
        if (act_vec !== exp_vec()) begin
            n_err++; $display("FAIL reset: got %h want %h", act_vec, exp_vec());
        end
        repeat (2) @(negedge clk_i);
        rstn_i = 1'b1;
    endtask

    task automatic test_all_equal();
        apply(1'b1, fill(32'hA5A5_A5A5), fill(32'hA5A5_A5A5), fill(32'hA5A5_A5A5), 1'b0, '0);
        n_cmp++;
        if (act_vec !== exp_vec()) begin
            n_err++; $display("FAIL all_equal: got %h want %h", act_vec, exp_vec());
        end
        n_cmp++;
        if ({out_o[3], error1_o, blame_o} !== {32'hA5A5_A5A5, 1'b0, 3'b000}) begin
            n_err++; $display("FAIL all_equal_fields: got %h/%b/%b want a5a5a5a5/0/000",
                              out_o[3], error1_o, blame_o);
        end
    endtask

    task automatic test_ch2_blame();
        logic [C-1:0][W-1:0] c;
        c = fill(32'h1234_5678);
        c[2] = 32'hDEAD_BEEF;
        apply(1'b1, fill(32'h1234_5678), fill(32'h1234_5678), c, 1'b0, '0);
        n_cmp++;
        if (act_vec !== exp_vec()) begin
            n_err++; $display("FAIL ch2_blame: got %h want %h", act_vec, exp_vec());
        end
        n_cmp++;
        if ({err1_ch_o, blame_o, sticky1_o, out_o[2]} !== {4'b0100, 3'b100, 1'b1, 32'h1234_5678}) begin
            n_err++; $display("FAIL ch2_fields: got %b/%b/%b/%h want 0100/100/1/12345678",
                              err1_ch_o, blame_o, sticky1_o, out_o[2]);
        end
    endtask

    task automatic test_all_differ();
        logic [C-1:0][W-1:0] a, b, c;
        a = fill(32'h0F0F_0F0F); b = a; c = a;
        a[0] = 32'h1111_1111; b[0] = 32'h2222_2222; c[0] = 32'h3333_3333;
        apply(1'b1, a, b, c, 1'b0, '0);
        n_cmp++;
        if (act_vec !== exp_vec()) begin
            n_err++; $display("FAIL all_differ: got %h want %h", act_vec, exp_vec());
        end
        n_cmp++;
        if ({err2_ch_o, error1_o, error2_o, blame_o, out_o[0]} !== {4'b0001, 2'b11, 3'b000, 32'h1111_1111}) begin
            n_err++; $display("FAIL all_differ_fields: got %b/%b%b/%b/%h want 0001/11/000/11111111",
                              err2_ch_o, error1_o, error2_o, blame_o, out_o[0]);
        end
    endtask

    task automatic test_clr_with_fault();
        logic [C-1:0][W-1:0] b;
        b = fill(32'h5555_0000);
        b[1] = 32'h5555_0001;
        apply(1'b1, fill(32'h5555_0000), b, fill(32'h5555_0000), 1'b1, 4'd1);
        n_cmp++;
        if (act_vec !== exp_vec()) begin
            n_err++; $display("FAIL clr_with_fault: got %h want %h", act_vec, exp_vec());
        end
        n_cmp++;
        if ({error1_o, sticky1_o, sticky2_o, cnt0_o, cnt1_o, cnt2_o, cntu_o, irq_o} !== {1'b1, 2'b00, 16'h0, 1'b0}) begin
            n_err++; $display("FAIL clr_fields: got e1=%b s=%b%b cnt=%h/%h/%h/%h irq=%b want e1=1 rest 0",
                              error1_o, sticky1_o, sticky2_o, cnt0_o, cnt1_o, cnt2_o, cntu_o, irq_o);
        end
    endtask

    task automatic test_saturation();
        logic [C-1:0][W-1:0] a;
        logic                want_irq;
        a = fill(32'hCAFE_0000);
        a[1] = 32'hCAFE_0BAD;
        for (int i = 0; i < 20; i++) begin
            apply(1'b1, a, fill(32'hCAFE_0000), fill(32'hCAFE_0000), 1'b0, 4'd5);
            n_cmp++;
            if (act_vec !== exp_vec()) begin
                n_err++; $display("FAIL saturation[%0d]: got %h want %h", i, act_vec, exp_vec());
            end
`ifdef TMR_VOTER_CNT_EN
            want_irq = (i >= 4);
`else
            want_irq = 1'b0;
`endif
            n_cmp++;
            if (irq_o !== want_irq) begin
                n_err++; $display("FAIL irq_threshold[%0d]: got %b want %b", i, irq_o, want_irq);
            end
        end
        n_cmp++;
`ifdef TMR_VOTER_CNT_EN
        if (cnt0_o !== 4'd15) begin
`else
        if (cnt0_o !== 4'd0) begin
`endif
            n_err++; $display("FAIL cnt0_saturate: got %0d", cnt0_o);
        end
    endtask

    task automatic test_idle();
        apply(1'b0, fill($urandom), fill($urandom), fill($urandom), 1'b0, 4'd5);
        n_cmp++;
        if (act_vec !== exp_vec()) begin
            n_err++; $display("FAIL idle: got %h want %h", act_vec, exp_vec());
        end
        n_cmp++;
        if ({valid_o, error1_o, blame_o, out_o[0]} !== {1'b0, 1'b0, 3'b000, 32'hCAFE_0000}) begin
            n_err++; $display("FAIL idle_hold: got %b/%b/%b/%h want 0/0/000/cafe0000",
                              valid_o, error1_o, blame_o, out_o[0]);
        end
    endtask

    task automatic test_reset_midstream();
        apply(1'b1, fill(32'h7777_7777), fill(32'h7777_7777), fill(32'h7777_0000), 1'b0, '0);
        in0_i = fill(32'h0BAD_0BAD);
        #2;
        rstn_i = 1'b0;
        model_reset();
        #1;
        n_cmp++;
        if (act_vec !== exp_vec()) begin
            n_err++; $display("FAIL reset_midstream: got %h want %h", act_vec, exp_vec());
        end
        valid_i = 1'b0;
        @(negedge clk_i);
        rstn_i = 1'b1;
        apply(1'b1, fill(32'h2468_ACE0), fill(32'h2468_ACE0), fill(32'h2468_ACE0), 1'b0, '0);
        n_cmp++;
        if (act_vec !== exp_vec()) begin
            n_err++; $display("FAIL after_reset_sample: got %h want %h", act_vec, exp_vec());
        end
    endtask

    task automatic test_random();
        logic [C-1:0][W-1:0] a, b, c;
        logic [W-1:0]        base;
        for (int n = 0; n < 300; n++) begin
            for (int ch = 0; ch < C; ch++) begin
                base = $urandom;
                a[ch] = base; b[ch] = base; c[ch] = base;
                case ($urandom_range(0, 4))
                    1: a[ch] = base ^ ($urandom | 32'h1);
                    2: b[ch] = base ^ ($urandom | 32'h1);
                    3: c[ch] = base ^ ($urandom | 32'h1);
                    4: begin
                        b[ch] = base ^ 32'h1 ^ ($urandom & 32'hFFFF_FF00);
                        c[ch] = base ^ 32'h2 ^ ($urandom & 32'hFFFF_FF00);
                    end
                    default: ;
                endcase
            end
            apply($urandom_range(0, 3) != 0, a, b, c, $urandom_range(0, 15) == 0,
                  CNT_W'($urandom_range(0, 15)));
            n_cmp++;
            if (act_vec !== exp_vec()) begin
                n_err++; $display("FAIL random[%0d]: got %h want %h", n, act_vec, exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_all_equal();
        test_ch2_blame();
        test_all_differ();
        test_clr_with_fault();
        test_saturation();
        test_idle();
        test_reset_midstream();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
